// File: rtl/alu_rs.sv
// Reservation station for ALU/branch-compare ops: snoops both CDBs, dispatches one ready op per cycle.
// Optional RS_OLDEST_FIRST_EN selects the oldest ready entry instead of the lowest index.
module alu_rs #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [4:0]       issue_op,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic             issue_q1_busy,
  input  logic [ROB_W-1:0] issue_q1,
  input  logic [31:0]      issue_v1,
  input  logic             issue_q2_busy,
  input  logic [ROB_W-1:0] issue_q2,
  input  logic [31:0]      issue_v2,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob_id,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob_id,
  input  logic [31:0]      cdb_lsb_value,
  output logic             full,
  output logic             alu_valid,
  output logic [4:0]       alu_op,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2,
  output logic [ROB_W-1:0] alu_rob_id
);

  localparam logic [IDX_W:0] FullThr = (IDX_W + 1)'(RS_SIZE - 1);

  logic [RS_SIZE-1:0] busy_q, busy_d, q1b_q, q1b_d, q2b_q, q2b_d, ready;
  logic [4:0]         op_q  [RS_SIZE];
  logic [4:0]         op_d  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];
  logic [ROB_W-1:0]   q1_q  [RS_SIZE];
  logic [ROB_W-1:0]   q1_d  [RS_SIZE];
  logic [ROB_W-1:0]   q2_q  [RS_SIZE];
  logic [ROB_W-1:0]   q2_d  [RS_SIZE];
  logic [31:0]        v1_q  [RS_SIZE];
  logic [31:0]        v1_d  [RS_SIZE];
  logic [31:0]        v2_q  [RS_SIZE];
  logic [31:0]        v2_d  [RS_SIZE];
`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W:0]     age_q [RS_SIZE];
  logic [IDX_W:0]     age_d [RS_SIZE];
  logic [IDX_W:0]     best_age;
`endif
  logic [IDX_W:0]     count_q, count_d;
  logic [IDX_W-1:0]   sel, free_idx;
  logic               sel_found, free_found, accept;

  // Returns {still_busy, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] resolve(input logic busy, input logic [ROB_W-1:0] q,
                                          input logic [31:0] v);
    if (busy && cdb_alu_valid && cdb_alu_rob_id == q) return {1'b0, cdb_alu_value};
    if (busy && cdb_lsb_valid && cdb_lsb_rob_id == q) return {1'b0, cdb_lsb_value};
    return {busy, v};
  endfunction

  assign ready  = busy_q & ~q1b_q & ~q2b_q;
  assign full   = count_q >= FullThr;
  assign accept = issue_valid && free_found;

  always_comb begin
    sel        = '0;
    sel_found  = 1'b0;
    free_idx   = '0;
    free_found = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
    best_age   = '0;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
`ifdef RS_OLDEST_FIRST_EN
      if (ready[i] && (!sel_found || age_q[i] > best_age)) begin
        sel_found = 1'b1;
        sel       = IDX_W'(i);
        best_age  = age_q[i];
      end
`else
      if (ready[i] && !sel_found) begin
        sel_found = 1'b1;
        sel       = IDX_W'(i);
      end
`endif
    end
  end

  always_comb begin
    busy_d = busy_q;
    q1b_d  = q1b_q;
    q2b_d  = q2b_q;
    op_d   = op_q;
    rob_d  = rob_q;
    q1_d   = q1_q;
    q2_d   = q2_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
`ifdef RS_OLDEST_FIRST_EN
    age_d  = age_q;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        {q1b_d[i], v1_d[i]} = resolve(q1b_q[i], q1_q[i], v1_q[i]);
        {q2b_d[i], v2_d[i]} = resolve(q2b_q[i], q2_q[i], v2_q[i]);
`ifdef RS_OLDEST_FIRST_EN
        if (accept) age_d[i] = age_q[i] + 1'b1;
`endif
      end
    end
    if (sel_found) busy_d[sel] = 1'b0;
    // Issue targets a slot free before this edge, so it never collides with the dispatched one.
    if (accept) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = issue_op;
      rob_d[free_idx]  = issue_rob_id;
      q1_d[free_idx]   = issue_q1;
      q2_d[free_idx]   = issue_q2;
      {q1b_d[free_idx], v1_d[free_idx]} = resolve(issue_q1_busy, issue_q1, issue_v1);
      {q2b_d[free_idx], v2_d[free_idx]} = resolve(issue_q2_busy, issue_q2, issue_v2);
`ifdef RS_OLDEST_FIRST_EN
      age_d[free_idx]  = '0;
`endif
    end
    count_d = count_q + (IDX_W + 1)'(accept) - (IDX_W + 1)'(sel_found);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      count_q    <= '0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_rob_id <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy_q    <= '0;
        count_q   <= '0;
        alu_valid <= 1'b0;
      end else begin
        busy_q    <= busy_d;
        q1b_q     <= q1b_d;
        q2b_q     <= q2b_d;
        op_q      <= op_d;
        rob_q     <= rob_d;
        q1_q      <= q1_d;
        q2_q      <= q2_d;
        v1_q      <= v1_d;
        v2_q      <= v2_d;
`ifdef RS_OLDEST_FIRST_EN
        age_q     <= age_d;
`endif
        count_q   <= count_d;
        alu_valid <= sel_found;
        if (sel_found) begin
          alu_op     <= op_q[sel];
          alu_v1     <= v1_q[sel];
          alu_v2     <= v2_q[sel];
          alu_rob_id <= rob_q[sel];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs; expected values are hand-computed per step.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        issue_valid, issue_q1_busy, issue_q2_busy;
  logic [4:0]  issue_op;
  logic [3:0]  issue_rob_id, issue_q1, issue_q2;
  logic [31:0] issue_v1, issue_v2;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [31:0] cdb_alu_value, cdb_lsb_value;
  logic        full, alu_valid;
  logic [4:0]  alu_op;
  logic [31:0] alu_v1, alu_v2;
  logic [3:0]  alu_rob_id;

  int total = 0;
  int bad   = 0;

  alu_rs #(.RS_SIZE(8), .ROB_W(4), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_q1_busy(issue_q1_busy), .issue_q1(issue_q1), .issue_v1(issue_v1),
    .issue_q2_busy(issue_q2_busy), .issue_q2(issue_q2), .issue_v2(issue_v2),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id),
    .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id),
    .cdb_lsb_value(cdb_lsb_value),
    .full(full), .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1),
    .alu_v2(alu_v2), .alu_rob_id(alu_rob_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] rob,
                       input logic b1, input logic [3:0] q1, input logic [31:0] v1,
                       input logic b2, input logic [3:0] q2, input logic [31:0] v2);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_rob_id  = rob;
    issue_q1_busy = b1;
    issue_q1      = q1;
    issue_v1      = v1;
    issue_q2_busy = b2;
    issue_q2      = q2;
    issue_v2      = v2;
  endtask

  task automatic quiet();
    issue_valid   = 1'b0;
    cdb_alu_valid = 1'b0;
    cdb_lsb_valid = 1'b0;
  endtask

  task automatic expect_disp(input string tag, input logic [4:0] op, input logic [3:0] rob,
                             input logic [31:0] v1, input logic [31:0] v2);
    check({tag, "_valid"}, {31'd0, alu_valid}, 32'd1);
    check({tag, "_op"}, {27'd0, alu_op}, {27'd0, op});
    check({tag, "_rob"}, {28'd0, alu_rob_id}, {28'd0, rob});
    check({tag, "_v1"}, alu_v1, v1);
    check({tag, "_v2"}, alu_v2, v2);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    issue_op = '0; issue_rob_id = '0; issue_q1_busy = 1'b0; issue_q1 = '0; issue_v1 = '0;
    issue_q2_busy = 1'b0; issue_q2 = '0; issue_v2 = '0;
    cdb_alu_rob_id = '0; cdb_alu_value = '0; cdb_lsb_rob_id = '0; cdb_lsb_value = '0;
    quiet();
    step(); step();
    rst = 1'b0;
    check("rst_valid", {31'd0, alu_valid}, 32'd0);
    check("rst_op", {27'd0, alu_op}, 32'd0);
    check("rst_v1", alu_v1, 32'd0);
    check("rst_v2", alu_v2, 32'd0);
    check("rst_rob", {28'd0, alu_rob_id}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);

    // Both operands ready at issue
    issue(5'h00, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    step(); quiet();
    check("t1_lat", {31'd0, alu_valid}, 32'd0);
    step();
    expect_disp("t1", 5'h00, 4'd3, 32'd5, 32'd7);
    step();
    check("t1_drop", {31'd0, alu_valid}, 32'd0);
    check("t1_hold", {28'd0, alu_rob_id}, 32'd3);

    // Source 1 delivered on the ALU bus a cycle later
    issue(5'h10, 4'd2, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1);
    step(); quiet();
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 4'd6; cdb_alu_value = 32'h10;
    step(); quiet();
    check("t2_wait", {31'd0, alu_valid}, 32'd0);
    step();
    expect_disp("t2", 5'h10, 4'd2, 32'h10, 32'd1);

    // Issue-time forwarding from the load bus
    issue(5'h0b, 4'd5, 1'b0, 4'd0, 32'd3, 1'b1, 4'd4, 32'd0);
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 4'd4; cdb_lsb_value = 32'hDEAD;
    step(); quiet();
    check("t3_lat", {31'd0, alu_valid}, 32'd0);
    step();
    expect_disp("t3", 5'h0b, 4'd5, 32'd3, 32'hDEAD);
    step();

    // Fill seven entries blocked on tag 9
    for (int i = 0; i < 7; i++) begin
      issue(5'h01, 4'(i), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(i));
      step();
      check("t4_fill_full", {31'd0, full}, (i == 6) ? 32'd1 : 32'd0);
    end
    quiet();
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 4'd9; cdb_alu_value = 32'h99;
    step(); quiet();
    check("t4_full7", {31'd0, full}, 32'd1);
    check("t4_wait", {31'd0, alu_valid}, 32'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      expect_disp("t4_drain", 5'h01, 4'(k), 32'h99, 32'(k));
      check("t4_drain_full", {31'd0, full}, 32'd0);
    end
    step();
    check("t4_idle", {31'd0, alu_valid}, 32'd0);

    // Clear alongside a ready issue
    for (int i = 0; i < 3; i++) begin
      issue(5'h02, 4'(10 + i), 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
    end
    issue(5'h02, 4'd14, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    clear = 1'b1;
    step(); clear = 1'b0; quiet();
    check("t5_clr_valid", {31'd0, alu_valid}, 32'd0);
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 4'd12; cdb_alu_value = 32'h5;
    step(); quiet();
    check("t5_post1", {31'd0, alu_valid}, 32'd0);
    step();
    check("t5_post2", {31'd0, alu_valid}, 32'd0);
    step();
    check("t5_post3", {31'd0, alu_valid}, 32'd0);
    // Count must have restarted from zero: six blocked issues leave full low
    for (int i = 0; i < 6; i++) begin
      issue(5'h02, 4'(1 + i), 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
    end
    quiet();
    check("t5_count6", {31'd0, full}, 32'd0);
    clear = 1'b1;
    step(); clear = 1'b0;

    // rdy freeze with a pending dispatch
    issue(5'h03, 4'd7, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22);
    step();
    rdy = 1'b0;
    issue(5'h04, 4'd8, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_frozen", {31'd0, alu_valid}, 32'd0);
    end
    quiet();
    rdy = 1'b1;
    step();
    expect_disp("t6", 5'h03, 4'd7, 32'h11, 32'h22);
    rdy = 1'b0;
    step();
    check("t6_hold_valid", {31'd0, alu_valid}, 32'd1);
    check("t6_hold_rob", {28'd0, alu_rob_id}, 32'd7);
    rdy = 1'b1;
    step();
    check("t6_no_ghost", {31'd0, alu_valid}, 32'd0);

    // Age ordering: older entry lands at index 1, younger at index 0
    issue(5'h05, 4'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
    step();
    issue(5'h05, 4'd2, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd2);
    step();
    expect_disp("t7_p", 5'h05, 4'd1, 32'd1, 32'd1);
    issue(5'h05, 4'd3, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd3);
    step(); quiet();
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = 4'd14; cdb_alu_value = 32'h44;
    step(); quiet();
    step();
`ifdef RS_OLDEST_FIRST_EN
    expect_disp("t7_first", 5'h05, 4'd2, 32'h44, 32'd2);
    step();
    expect_disp("t7_second", 5'h05, 4'd3, 32'h44, 32'd3);
`else
    expect_disp("t7_first", 5'h05, 4'd3, 32'h44, 32'd3);
    step();
    expect_disp("t7_second", 5'h05, 4'd2, 32'h44, 32'd2);
`endif
    step();
    check("t7_idle", {31'd0, alu_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
